dot_product_reader: RTL and testbench

DOT_PRODUCT_READER -- requirements
Module: dot_product_reader

---
 rtl/dot_product_pkg.sv | 17 +
 rtl/dot_product_mac.sv | 38 +++
 rtl/dot_product_reader.sv | 124 ++++++++++++
 tb/tb_dot_product_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product reader and its MAC datapath.
package dot_product_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    OUT  = 3'd4
  } state_t;

  // Accumulator width that can hold VECTOR_LEN full-precision products without overflow.
  function automatic int acc_width_f(input int data_width, input int vector_len);
    return 2 * data_width + $clog2(vector_len);
  endfunction

endpackage

// File: rtl/dot_product_mac.sv
// Registered unsigned multiply-accumulate with synchronous clear and enable.
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [2*DATA_WIDTH-1:0] product;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [ACC_WIDTH-1:0]    acc_d;

  // Full-precision product and the running sum it feeds.
  always_comb begin
    product = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
    acc_d   = acc_q + ACC_WIDTH'(product);
  end

  // Accumulator register: reset and clear both zero it, enable adds one product.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dot_product_reader.sv
// Reads two vectors element by element from a single memory read port and
// returns their unsigned dot product through a valid/ready result handshake.
module dot_product_reader
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int VECTOR_LEN = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int ACC_WIDTH  = acc_width_f(DATA_WIDTH, VECTOR_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int IDX_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_LEN - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] a_reg_q, a_reg_d;
  logic                  mac_clear;
  logic                  mac_en;
  logic [ACC_WIDTH-1:0]  acc;

  // Next-state, read strobe and datapath controls; everything defaults to "hold, no read".
  always_comb begin
    state_d     = state_q;
    base_a_d    = base_a_q;
    base_b_d    = base_b_q;
    idx_d       = idx_q;
    a_reg_d     = a_reg_q;
    mac_clear   = 1'b0;
    mac_en      = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_a_d  = base_a;
          base_b_d  = base_b;
          idx_d     = '0;
          mac_clear = 1'b1;
          state_d   = RD_A;
        end
      end
      RD_A: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_a_q + ADDR_WIDTH'(idx_q);
        state_d     = RD_B;
      end
      RD_B: begin
        a_reg_d     = mem_rd_data;
        mem_rd_en   = 1'b1;
        mem_rd_addr = base_b_q + ADDR_WIDTH'(idx_q);
        state_d     = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = OUT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_A;
        end
      end
      OUT: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers; reset wins over any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      idx_q    <= '0;
      a_reg_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      idx_q    <= idx_d;
      a_reg_q  <= a_reg_d;
    end
  end

  // B data arrives in the MAC cycle straight from memory, so it feeds the multiplier unregistered.
  dot_product_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear_i(mac_clear),
    .en_i   (mac_en),
    .a_i    (a_reg_q),
    .b_i    (mem_rd_data),
    .acc_o  (acc)
  );

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == OUT);
  assign result       = acc;

endmodule

// File: tb/tb_dot_product_reader.sv
// Directed bench for dot_product_reader with a cycle-level reference model.
module tb_dot_product_reader;

  localparam int DW   = 8;
  localparam int VL   = 4;
  localparam int AW   = 5;
  localparam int ACCW = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base_a;
  logic [AW-1:0]   base_b;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_data = '0;
  logic            busy;
  logic [ACCW-1:0] result;
  logic            result_valid;
  logic            result_ready;

  logic [DW-1:0]   mem [0:31];
  logic [AW-1:0]   addrLog [$];
  int              errors = 0;
  int              checks = 0;

  dot_product_reader #(
    .DATA_WIDTH(DW),
    .VECTOR_LEN(VL),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_a      (base_a),
    .base_b      (base_b),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Memory with one cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Record every address the DUT reads.
  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) addrLog.push_back(mem_rd_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference dot product straight from memory contents with modulo-32 addressing.
  function automatic int refDot(input logic [AW-1:0] ba, input logic [AW-1:0] bb);
    int s;
    logic [AW-1:0] pa, pb;
    s = 0;
    for (int i = 0; i < VL; i++) begin
      pa = ba + AW'(i);
      pb = bb + AW'(i);
      s += int'(mem[pa]) * int'(mem[pb]);
    end
    return s;
  endfunction

  // Model: a run takes 3 edges per element, reads A then B, then holds the result until ready.
  bit            mActive = 1'b0;
  bit            mBusy   = 1'b0;
  bit            mValid  = 1'b0;
  int            mT      = 0;
  int            mExp    = 0;
  int            mResult = 0;
  logic [AW-1:0] mBa     = '0;
  logic [AW-1:0] mBb     = '0;

  always @(posedge clk) begin
    if (rst) begin
      mActive = 1'b1;
      mBusy   = 1'b0;
      mValid  = 1'b0;
      mT      = 0;
      mResult = 0;
    end else if (!mBusy) begin
      if (start) begin
        mBusy = 1'b1;
        mT    = 0;
        mBa   = base_a;
        mBb   = base_b;
        mExp  = refDot(base_a, base_b);
      end
    end else if (mValid) begin
      if (result_ready) begin
        mBusy  = 1'b0;
        mValid = 1'b0;
      end
    end else begin
      mT++;
      if (mT == 3 * VL) begin
        mValid  = 1'b1;
        mResult = mExp;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin : compare
    int ph;
    logic [AW-1:0] ea;
    if (mActive) begin
      checkOutput("busy", busy, mBusy);
      checkOutput("result_valid", result_valid, mValid);
      if (mBusy && !mValid) begin
        ph = mT % 3;
        ea = ((ph == 0) ? mBa : mBb) + AW'(mT / 3);
        checkOutput("rd_en", mem_rd_en, (ph != 2));
        if (ph != 2) checkOutput("rd_addr", mem_rd_addr, ea);
      end else begin
        checkOutput("rd_en_quiet", mem_rd_en, 0);
        checkOutput("result", result, mResult);
      end
    end
  end

  // One full transaction: start, wait for valid, optionally stall ready, then complete the transfer.
  task automatic applyStimulus(input string tag, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                               input bit holdStart, input int readyDelay, input int expResult);
    int edges;
    edges        = 0;
    base_a       = ba;
    base_b       = bb;
    start        = 1'b1;
    result_ready = (readyDelay == 0);
    @(posedge clk);
    @(negedge clk);
    if (!holdStart) start = 1'b0;
    while (result_valid !== 1'b1 && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput({tag, "_latency"}, edges, 12);
    checkOutput({tag, "_result"}, result, expResult);
    repeat (readyDelay) begin
      @(negedge clk);
      checkOutput({tag, "_held_valid"}, result_valid, 1);
      checkOutput({tag, "_held_result"}, result, expResult);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({tag, "_busy_after"}, busy, 0);
    checkOutput({tag, "_valid_after"}, result_valid, 0);
    checkOutput({tag, "_retained"}, result, expResult);
    start = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_stays_idle"}, busy, 0);
  endtask

  // Abort watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int expAddr [8];
    expAddr = '{30, 2, 31, 3, 0, 4, 1, 5};
    rst          = 1'b1;
    start        = 1'b0;
    base_a       = '0;
    base_b       = '0;
    result_ready = 1'b0;
    for (int k = 0; k < 32; k++) mem[k] = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", result_valid, 0);
    checkOutput("reset_rd_en", mem_rd_en, 0);
    checkOutput("reset_addr", mem_rd_addr, 0);
    checkOutput("reset_result", result, 0);
    rst = 1'b0;

    $display("[TB] basic vectors, ready already high");
    for (int k = 0; k < 8; k++) mem[k] = DW'(k + 1);
    checkOutput("model_pin_basic", refDot(5'd0, 5'd4), 70);
    applyStimulus("basic", 5'd0, 5'd4, 1'b0, 0, 70);

    $display("[TB] all 255, ready stalled 5 cycles");
    for (int k = 0; k < 8; k++) mem[k] = 8'd255;
    applyStimulus("max", 5'd0, 5'd4, 1'b0, 5, 260100);

    $display("[TB] wrapping addresses, start held high");
    mem[30] = 8'd10; mem[31] = 8'd20; mem[0] = 8'd30; mem[1] = 8'd40;
    mem[2]  = 8'd1;  mem[3]  = 8'd2;  mem[4] = 8'd3;  mem[5] = 8'd4;
    checkOutput("model_pin_wrap", refDot(5'd30, 5'd2), 300);
    addrLog.delete();
    applyStimulus("wrap", 5'd30, 5'd2, 1'b1, 0, 300);
    checkOutput("wrap_read_count", addrLog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < addrLog.size()) checkOutput("wrap_addr_order", addrLog[k], expAddr[k]);
    end

    $display("[TB] reset after second MAC, then fresh run");
    for (int k = 0; k < 8; k++) mem[k] = DW'(k + 1);
    base_a = 5'd0;
    base_b = 5'd4;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", result_valid, 0);
    checkOutput("abort_rd_en", mem_rd_en, 0);
    checkOutput("abort_addr", mem_rd_addr, 0);
    checkOutput("abort_result", result, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", busy, 0);
    applyStimulus("fresh", 5'd0, 5'd4, 1'b0, 2, 70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
